// File: rtl/dcm_prog_if.sv
// Request / DCM programming bundle for dcm_prog_tx.
// master: requester plus DCM side; slave: the programming transmitter.
`timescale 1ns/1ps
interface dcm_prog_if;
    logic       req_valid;
    logic [7:0] req_m;
    logic       req_ready;
    logic       prog_data;
    logic       prog_en;
    logic       prog_done;
    logic       busy;
    logic [7:0] current_m;
    logic       done_pulse;
    logic       timeout_err;

    modport master (
        output req_valid, req_m, prog_done,
        input  req_ready, prog_data, prog_en, busy, current_m, done_pulse, timeout_err
    );

    modport slave (
        input  req_valid, req_m, prog_done,
        output req_ready, prog_data, prog_en, busy, current_m, done_pulse, timeout_err
    );
endinterface

// File: rtl/dcm_prog_tx.sv
// Serial programming transmitter for a DCM_CLKGEN.
// Clamps a requested M, shifts out LoadD / LoadM / GO on prog_data/prog_en,
// then waits for prog_done with a timeout. Programs BOOT_M after reset.
`timescale 1ns/1ps
module dcm_prog_tx #(
    parameter int INPUT_FREQUENCY   = 100,
    parameter int DIVIDE            = 50,
    parameter int MAXIMUM_FREQUENCY = 250,
    parameter int INITIAL_FREQUENCY = 50,
    parameter int DONE_TIMEOUT      = 4096
) (
    input logic       clk,
    input logic       rst_n,
    dcm_prog_if.slave bus
);

    localparam logic [7:0] MAX_M  = 8'(MAXIMUM_FREQUENCY * DIVIDE / INPUT_FREQUENCY);
    localparam logic [7:0] BOOT_M = 8'(INITIAL_FREQUENCY * DIVIDE / INPUT_FREQUENCY);
    localparam logic [7:0] D_WORD = 8'(DIVIDE - 1);
    localparam int         TW     = $clog2(DONE_TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'(DONE_TIMEOUT - 1);

    // Frames are sent bit 0 first: two command bits, then the payload LSB first.
    localparam logic [9:0] LOADD_WORD = {D_WORD, 2'b01};

    typedef enum logic [2:0] {
        BOOT, IDLE, LOADD, GAP1, LOADM, GAP2, GO, WAIT_DONE
    } state_t;

    state_t        state;
    logic [7:0]    target_m;
    logic [9:0]    shreg;
    logic [3:0]    bit_cnt;
    logic [TW-1:0] to_cnt;
    logic [7:0]    clamped_m;
    logic [9:0]    loadm_word;

    // Clamp the requested multiplier into the safe range [2, MAX_M].
    always_comb begin
        clamped_m = bus.req_m;
        if (bus.req_m < 8'd2) begin
            clamped_m = 8'd2;
        end else if (bus.req_m > MAX_M) begin
            clamped_m = MAX_M;
        end
    end

    // LoadM frame built from the latched target.
    always_comb begin
        loadm_word = {target_m - 8'd1, 2'b11};
    end

    // Sequencer: every output is registered so the DCM sees clean levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= BOOT;
            target_m        <= 8'd0;
            shreg           <= 10'd0;
            bit_cnt         <= 4'd0;
            to_cnt          <= '0;
            bus.prog_en     <= 1'b0;
            bus.prog_data   <= 1'b0;
            bus.req_ready   <= 1'b0;
            bus.busy        <= 1'b1;
            bus.current_m   <= 8'd0;
            bus.done_pulse  <= 1'b0;
            bus.timeout_err <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments everywhere here, so every branch
            // sees the register values from before this edge. The default
            // below makes done_pulse a single-cycle strobe.
            bus.done_pulse <= 1'b0;
            case (state)
                BOOT: begin
                    target_m      <= BOOT_M;
                    state         <= LOADD;
                    bus.prog_en   <= 1'b1;
                    bus.prog_data <= LOADD_WORD[0];
                    shreg         <= LOADD_WORD >> 1;
                    bit_cnt       <= 4'd0;
                end
                IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        target_m        <= clamped_m;
                        bus.timeout_err <= 1'b0;
                        bus.req_ready   <= 1'b0;
                        bus.busy        <= 1'b1;
                        state           <= LOADD;
                        bus.prog_en     <= 1'b1;
                        bus.prog_data   <= LOADD_WORD[0];
                        shreg           <= LOADD_WORD >> 1;
                        bit_cnt         <= 4'd0;
                    end
                end
                LOADD: begin
                    if (bit_cnt == 4'd9) begin
                        state         <= GAP1;
                        bus.prog_en   <= 1'b0;
                        bus.prog_data <= 1'b0;
                    end else begin
                        bus.prog_data <= shreg[0];
                        shreg         <= {1'b0, shreg[9:1]};
                        bit_cnt       <= bit_cnt + 4'd1;
                    end
                end
                GAP1: begin
                    state         <= LOADM;
                    bus.prog_en   <= 1'b1;
                    bus.prog_data <= loadm_word[0];
                    shreg         <= loadm_word >> 1;
                    bit_cnt       <= 4'd0;
                end
                LOADM: begin
                    if (bit_cnt == 4'd9) begin
                        state         <= GAP2;
                        bus.prog_en   <= 1'b0;
                        bus.prog_data <= 1'b0;
                    end else begin
                        bus.prog_data <= shreg[0];
                        shreg         <= {1'b0, shreg[9:1]};
                        bit_cnt       <= bit_cnt + 4'd1;
                    end
                end
                GAP2: begin
                    state         <= GO;
                    bus.prog_en   <= 1'b1;
                    bus.prog_data <= 1'b0;
                end
                GO: begin
                    state       <= WAIT_DONE;
                    bus.prog_en <= 1'b0;
                    to_cnt      <= '0;
                end
                WAIT_DONE: begin
                    if (bus.prog_done) begin
                        bus.current_m  <= target_m;
                        bus.done_pulse <= 1'b1;
                        bus.req_ready  <= 1'b1;
                        bus.busy       <= 1'b0;
                        state          <= IDLE;
                    end else if (to_cnt == TO_LAST) begin
                        bus.timeout_err <= 1'b1;
                        bus.req_ready   <= 1'b1;
                        bus.busy        <= 1'b0;
                        state           <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule
